gl_tri_scheduler: RTL

//  Assembles a vertex stream (triangle list or strip) into triangles and issues them one
//  at a time to the rasterizer core. Sits between the transform/vertex FIFO and the

---
 rtl/gl_pkg.sv | 36 +++
 rtl/gl_tri_assembler.sv | 107 ++++++++++
 rtl/gl_tri_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gl_pkg.sv
// Shared definitions for the triangle setup path: vertex layout, scheduler states and
// primitive mode encodings.
package gl_pkg;

   localparam int VTX_W = 96;

   // Vertex word layout: x and y are fp32, the low word carries z/attribute data.
   localparam int X_MSB = 95;
   localparam int X_LSB = 64;
   localparam int Y_MSB = 63;
   localparam int Y_LSB = 32;
   localparam int Z_MSB = 31;
   localparam int Z_LSB = 0;

   localparam logic MODE_LIST  = 1'b0;
   localparam logic MODE_STRIP = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sched_state_t;

   function automatic logic [31:0] vtx_x(input logic [VTX_W-1:0] v);
      return v[X_MSB:X_LSB];
   endfunction

   function automatic logic [31:0] vtx_y(input logic [VTX_W-1:0] v);
      return v[Y_MSB:Y_LSB];
   endfunction

   function automatic logic [31:0] vtx_z(input logic [VTX_W-1:0] v);
      return v[Z_MSB:Z_LSB];
   endfunction

endpackage

// File: rtl/gl_tri_assembler.sv
// Turns accepted vertices into triangles (list or strip), preserving strip winding and
// counting vertices left over when a primitive ends mid-triangle.
module gl_tri_assembler
   import gl_pkg::*;
#(
   parameter int VTX_W = gl_pkg::VTX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             prim_start,
   input  logic             vtx_accept,
   input  logic             vtx_last,
   input  logic [VTX_W-1:0] vtx_data,
   output logic             tri_valid,
   output logic [VTX_W-1:0] tri_v1,
   output logic [VTX_W-1:0] tri_v2,
   output logic [VTX_W-1:0] tri_v3,
   output logic [1:0]       drop_inc,
   output logic             prim_open
);

   logic             mode_reg, mode_next;
   logic [VTX_W-1:0] h0_reg, h0_next;
   logic [VTX_W-1:0] h1_reg, h1_next;
   logic [1:0]       cnt_reg, cnt_next;
   logic             odd_reg, odd_next;
   logic             open_reg, open_next;

   // prim_start takes effect before a vertex arriving in the same cycle.
   logic       mode_eff;
   logic [1:0] cnt_eff;
   logic       odd_eff;
   logic       completes;

   assign mode_eff  = prim_start ? mode : mode_reg;
   assign cnt_eff   = prim_start ? 2'd0 : cnt_reg;
   assign odd_eff   = prim_start ? 1'b0 : odd_reg;
   assign completes = vtx_accept && (cnt_eff == 2'd2);

   always_comb begin
      mode_next = mode_eff;
      h0_next   = h0_reg;
      h1_next   = h1_reg;
      cnt_next  = cnt_eff;
      odd_next  = odd_eff;
      open_next = prim_start | open_reg;
      tri_valid = completes;
      tri_v1    = h0_reg;
      tri_v2    = h1_reg;
      tri_v3    = vtx_data;
      drop_inc  = 2'd0;
      if (vtx_accept) begin
         open_next = 1'b1;
         if (completes) begin
            if (mode_eff == MODE_STRIP) begin
               // Odd strip triangles swap the two history vertices to keep winding.
               if (odd_eff) begin
                  tri_v1 = h1_reg;
                  tri_v2 = h0_reg;
               end
               h0_next  = h1_reg;
               h1_next  = vtx_data;
               odd_next = ~odd_eff;
            end else begin
               cnt_next = 2'd0;
            end
         end else begin
            if (cnt_eff == 2'd0) begin
               h0_next = vtx_data;
            end else begin
               h1_next = vtx_data;
            end
            cnt_next = cnt_eff + 2'd1;
         end
         if (vtx_last) begin
            if (!completes) begin
               drop_inc = cnt_eff + 2'd1;
            end
            cnt_next  = 2'd0;
            odd_next  = 1'b0;
            open_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg <= MODE_LIST;
         h0_reg   <= '0;
         h1_reg   <= '0;
         cnt_reg  <= 2'd0;
         odd_reg  <= 1'b0;
         open_reg <= 1'b0;
      end else begin
         mode_reg <= mode_next;
         h0_reg   <= h0_next;
         h1_reg   <= h1_next;
         cnt_reg  <= cnt_next;
         odd_reg  <= odd_next;
         open_reg <= open_next;
      end
   end

   assign prim_open = open_reg;

endmodule

// File: rtl/gl_tri_scheduler.sv
// Two-slot triangle buffer between vertex assembly and the rasterizer, with a
// start/done issue FSM and a watchdog on the done handshake.
module gl_tri_scheduler
   import gl_pkg::*;
#(
   parameter int          VTX_W   = gl_pkg::VTX_W,
   parameter int          CNT_W   = 16,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             prim_start,
   input  logic             vtx_valid,
   input  logic [VTX_W-1:0] vtx_data,
   input  logic             vtx_last,
   output logic             vtx_ready,
   output logic             rast_start,
   output logic [VTX_W-1:0] rast_v1,
   output logic [VTX_W-1:0] rast_v2,
   output logic [VTX_W-1:0] rast_v3,
   input  logic             rast_done,
   output logic             busy,
   output logic             timeout,
   output logic [CNT_W-1:0] tri_count,
   output logic [CNT_W-1:0] drop_count
);

   sched_state_t     state_reg;
   logic             rast_start_reg;
   logic [VTX_W-1:0] rast_v1_reg, rast_v2_reg, rast_v3_reg;
   logic             timeout_reg;
   logic [CNT_W-1:0] tri_count_reg, drop_count_reg;
   logic [31:0]      wd_cnt_reg;
   logic [1:0]       slot_full_reg, slot_full_next;
   logic             wr_ptr_reg, rd_ptr_reg;

   logic             vtx_accept;
   logic             tri_valid;
   logic [VTX_W-1:0] tri_v1, tri_v2, tri_v3;
   logic [1:0]       drop_inc;
   logic             prim_open;

   logic [VTX_W-1:0] slot_v1 [2];
   logic [VTX_W-1:0] slot_v2 [2];
   logic [VTX_W-1:0] slot_v3 [2];

   assign vtx_ready  = ~(slot_full_reg[0] & slot_full_reg[1]);
   assign vtx_accept = vtx_valid & vtx_ready;

   gl_tri_assembler #(.VTX_W(VTX_W)) u_asm (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .prim_start (prim_start),
      .vtx_accept (vtx_accept),
      .vtx_last   (vtx_last),
      .vtx_data   (vtx_data),
      .tri_valid  (tri_valid),
      .tri_v1     (tri_v1),
      .tri_v2     (tri_v2),
      .tri_v3     (tri_v3),
      .drop_inc   (drop_inc),
      .prim_open  (prim_open)
   );

   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic [VTX_W-1:0] v1_reg, v2_reg, v3_reg;

      always_ff @(posedge clk) begin
         if (tri_valid && (wr_ptr_reg == 1'(gi))) begin
            v1_reg <= tri_v1;
            v2_reg <= tri_v2;
            v3_reg <= tri_v3;
         end
      end

      assign slot_v1[gi] = v1_reg;
      assign slot_v2[gi] = v2_reg;
      assign slot_v3[gi] = v3_reg;
   end

   logic wd_expire;
   logic release_slot;

   assign wd_expire    = (TIMEOUT != 0) && (state_reg == WAIT) && (wd_cnt_reg == TIMEOUT - 1);
   assign release_slot = (state_reg == WAIT) && (rast_done || wd_expire);

   // Next triangle to issue: oldest slot from IDLE, the other slot after a release.
   // A triangle being written this cycle is forwarded so IDLE issues with one cycle latency.
   logic             cand_idx;
   logic             cand_in_slot;
   logic             cand_avail;
   logic             issue_go;
   logic [VTX_W-1:0] cand_v1, cand_v2, cand_v3;

   assign cand_idx     = (state_reg == IDLE) ? rd_ptr_reg : ~rd_ptr_reg;
   assign cand_in_slot = slot_full_reg[cand_idx];
   assign cand_avail   = cand_in_slot | (tri_valid & (wr_ptr_reg == cand_idx));
   assign issue_go     = cand_avail & ((state_reg == IDLE) | release_slot);
   assign cand_v1      = cand_in_slot ? slot_v1[cand_idx] : tri_v1;
   assign cand_v2      = cand_in_slot ? slot_v2[cand_idx] : tri_v2;
   assign cand_v3      = cand_in_slot ? slot_v3[cand_idx] : tri_v3;

   always_comb begin
      slot_full_next = slot_full_reg;
      if (release_slot) begin
         slot_full_next[rd_ptr_reg] = 1'b0;
      end
      if (tri_valid) begin
         slot_full_next[wr_ptr_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         rast_start_reg <= 1'b0;
         rast_v1_reg    <= '0;
         rast_v2_reg    <= '0;
         rast_v3_reg    <= '0;
         timeout_reg    <= 1'b0;
         tri_count_reg  <= '0;
         drop_count_reg <= '0;
         wd_cnt_reg     <= '0;
         slot_full_reg  <= 2'b00;
         wr_ptr_reg     <= 1'b0;
         rd_ptr_reg     <= 1'b0;
      end else begin
         slot_full_reg  <= slot_full_next;
         drop_count_reg <= drop_count_reg + CNT_W'(drop_inc);
         rast_start_reg <= 1'b0;
         if (tri_valid) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (release_slot) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         if (prim_start) begin
            timeout_reg <= 1'b0;
         end
         if (wd_expire) begin
            timeout_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: ;
            ISSUE: begin
               state_reg  <= WAIT;
               wd_cnt_reg <= '0;
            end
            WAIT: begin
               if (release_slot) begin
                  state_reg <= IDLE;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + 32'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (issue_go) begin
            state_reg      <= ISSUE;
            rast_start_reg <= 1'b1;
            rast_v1_reg    <= cand_v1;
            rast_v2_reg    <= cand_v2;
            rast_v3_reg    <= cand_v3;
            tri_count_reg  <= tri_count_reg + CNT_W'(1);
         end
      end
   end

   assign rast_start = rast_start_reg;
   assign rast_v1    = rast_v1_reg;
   assign rast_v2    = rast_v2_reg;
   assign rast_v3    = rast_v3_reg;
   assign timeout    = timeout_reg;
   assign tri_count  = tri_count_reg;
   assign drop_count = drop_count_reg;
   assign busy       = (|slot_full_reg) | (state_reg != IDLE) | prim_open;

endmodule
